// File: rtl/ad7763_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad7763_pkg
// Purpose  : Frame geometry and receiver state encoding for the AD7763 path.
// Revision : 1.0  initial release
// ============================================================================
package ad7763_pkg;

    localparam int AD7763_FRAME_BITS  = 32;
    localparam int AD7763_DATA_BITS   = 24;
    localparam int AD7763_STATUS_BITS = 8;
    localparam int AD7763_EXT_BITS    = AD7763_FRAME_BITS - AD7763_DATA_BITS;

    localparam logic [1:0] ST_WAIT_HI = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;

    typedef enum logic [1:0] {
        S_WAIT_HI = ST_WAIT_HI,
        S_ARMED   = ST_ARMED,
        S_SHIFT   = ST_SHIFT
    } rx_state_t;

endpackage : ad7763_pkg
`default_nettype wire

// File: rtl/axis_ad7763_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_ad7763_rx_if
// Purpose  : AXI4-Stream beat carrying one AD7763 frame (data + status byte).
// Revision : 1.0  initial release
// ============================================================================
interface axis_ad7763_rx_if;

    logic [ad7763_pkg::AD7763_FRAME_BITS-1:0]  tdata;
    logic [ad7763_pkg::AD7763_STATUS_BITS-1:0] tuser;
    logic                                      tvalid;
    logic                                      tready;

    modport master (output tdata, output tuser, output tvalid, input  tready);
    modport slave  (input  tdata, input  tuser, input  tvalid, output tready);

endinterface : axis_ad7763_rx_if
`default_nettype wire

// File: rtl/ad7763_in_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad7763_in_sync
// Purpose  : WIDTH-bit, STAGES-deep flip-flop synchronizer for ADC port pins.
// Revision : 1.0  initial release
// ============================================================================
module ad7763_in_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  wire logic             aclk,
    input  wire logic             aresetn,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    if (STAGES < 2 || STAGES > 4) begin : g_stages_check
        $error("ad7763_in_sync: STAGES must be within 2..4");
    end

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], d};
        end
    end

    assign q = r_stage[STAGES-1];

endmodule : ad7763_in_sync
`default_nettype wire

// File: rtl/axis_ad7763_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_ad7763_rx
// Purpose  : Oversampling AD7763 serial-port receiver emitting one AXI4-Stream
//            beat per 32-bit frame, with dropped/malformed frame counters.
// Revision : 1.0  initial release
// ============================================================================
module axis_ad7763_rx
    import ad7763_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit SIGN_EXTEND = 1'b1
) (
    input  wire logic        aclk,
    input  wire logic        aresetn,
    input  wire logic        adc_sco,
    input  wire logic        adc_fso,
    input  wire logic        adc_sdo,
    axis_ad7763_rx_if.master m_axis,
    output logic [15:0]      overflow_cnt,
    output logic [7:0]       frame_err_cnt,
    input  wire logic        cnt_clear
);

    localparam logic [5:0] C_LAST_BIT_IDX = 6'(AD7763_FRAME_BITS - 1);

    logic [2:0]                       w_sync;
    logic                             w_sco;
    logic                             w_fso;
    logic                             w_sdo;
    logic                             r_sco_d;
    logic                             w_rise;

    rx_state_t                        r_state;
    rx_state_t                        w_state_nxt;
    logic [AD7763_FRAME_BITS-1:0]     r_sr;
    logic [AD7763_FRAME_BITS-1:0]     w_sr_nxt;
    logic [5:0]                       r_bitcnt;
    logic [5:0]                       w_bitcnt_nxt;
    logic                             w_frame_err;
    logic                             w_frame_done;
    logic                             r_done;

    logic [AD7763_FRAME_BITS-1:0]     r_tdata;
    logic [AD7763_STATUS_BITS-1:0]    r_tuser;
    logic                             r_tvalid;
    logic                             w_load;
    logic                             w_ovf_inc;
    logic [AD7763_EXT_BITS-1:0]       w_ext;

    ad7763_in_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_in_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       ({adc_sdo, adc_fso, adc_sco}),
        .q       (w_sync)
    );

    assign w_sco  = w_sync[0];
    assign w_fso  = w_sync[1];
    assign w_sdo  = w_sync[2];
    assign w_rise = w_sco & ~r_sco_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sco_d  <= 1'b0;
            r_state  <= S_WAIT_HI;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_sco_d  <= w_sco;
            r_state  <= w_state_nxt;
            r_sr     <= w_sr_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_done   <= w_frame_done;
        end
    end

    // Everything advances only on a synchronized SCO rising edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_sr_nxt     = r_sr;
        w_bitcnt_nxt = r_bitcnt;
        w_frame_err  = 1'b0;
        w_frame_done = 1'b0;
        if (w_rise) begin
            case (r_state)
                S_WAIT_HI: begin
                    if (w_fso) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!w_fso) begin
                        w_sr_nxt     = {{(AD7763_FRAME_BITS-1){1'b0}}, w_sdo};
                        w_bitcnt_nxt = 6'd1;
                        w_state_nxt  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_fso) begin
                        w_frame_err  = 1'b1;
                        w_sr_nxt     = '0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = S_ARMED;
                    end else begin
                        w_sr_nxt     = {r_sr[AD7763_FRAME_BITS-2:0], w_sdo};
                        w_bitcnt_nxt = r_bitcnt + 6'd1;
                        if (r_bitcnt == C_LAST_BIT_IDX) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = S_WAIT_HI;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_WAIT_HI;
                end
            endcase
        end
    end

    // A finished frame loads when the holding register is empty or draining now.
    assign w_load    = r_done & (~r_tvalid | m_axis.tready);
    assign w_ovf_inc = r_done & r_tvalid & ~m_axis.tready;
    assign w_ext     = SIGN_EXTEND ? {AD7763_EXT_BITS{r_sr[AD7763_FRAME_BITS-1]}}
                                   : {AD7763_EXT_BITS{1'b0}};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
        end else if (w_load) begin
            r_tdata  <= {w_ext, r_sr[AD7763_FRAME_BITS-1:AD7763_STATUS_BITS]};
            r_tuser  <= r_sr[AD7763_STATUS_BITS-1:0];
            r_tvalid <= 1'b1;
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tuser  = r_tuser;
    assign m_axis.tvalid = r_tvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_cnt  <= '0;
            frame_err_cnt <= '0;
        end else if (cnt_clear) begin
            overflow_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (w_ovf_inc && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            if (w_frame_err && (frame_err_cnt != 8'hFF)) begin
                frame_err_cnt <= frame_err_cnt + 8'd1;
            end
        end
    end

endmodule : axis_ad7763_rx
`default_nettype wire

// File: tb/tb_axis_ad7763_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_ad7763_rx
// Purpose  : Self-checking bench driving AD7763 serial frames into the receiver.
// Revision : 1.0  initial release
// ============================================================================
module tb_axis_ad7763_rx;

    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic sco = 1'b0;
    logic fso = 1'b1;
    logic sdo = 1'b0;
    logic clr = 1'b0;

    logic [15:0] ovf;
    logic [7:0]  ferr;
    logic [15:0] z_ovf;
    logic [7:0]  z_ferr;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_rise = 0;
    int v_rise_cyc = -1;
    logic prev_v = 1'b0;
    logic [39:0] got[$];

    logic [15:0] exp_ovf = '0;
    logic [7:0]  exp_ferr = '0;
    bit          model_full = 0;
    logic [39:0] model_held = '0;

    axis_ad7763_rx_if m_axis ();
    axis_ad7763_rx_if z_axis ();
    assign z_axis.tready = 1'b1;

    axis_ad7763_rx #(.SYNC_STAGES(SYNC), .SIGN_EXTEND(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn), .adc_sco(sco), .adc_fso(fso), .adc_sdo(sdo),
        .m_axis(m_axis), .overflow_cnt(ovf), .frame_err_cnt(ferr), .cnt_clear(clr));

    axis_ad7763_rx #(.SYNC_STAGES(3), .SIGN_EXTEND(1'b0)) dut_z (
        .aclk(aclk), .aresetn(aresetn), .adc_sco(sco), .adc_fso(fso), .adc_sdo(sdo),
        .m_axis(z_axis), .overflow_cnt(z_ovf), .frame_err_cnt(z_ferr), .cnt_clear(clr));

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    always @(negedge aclk) begin
        if (m_axis.tvalid && !prev_v) v_rise_cyc = cyc;
        prev_v = m_axis.tvalid;
        if (m_axis.tvalid && m_axis.tready) got.push_back({m_axis.tdata, m_axis.tuser});
    end

    function automatic logic [39:0] beat_of(input logic [31:0] w);
        return {{8{w[31]}}, w[31:8], w[7:0]};
    endfunction

    // hook 1: pulse tready on the load cycle; 2: pulse cnt_clear there; 3: release reset at bit 10
    task automatic send_frame(input logic [31:0] w, input int nbits, input int hook);
        for (int i = 0; i < nbits; i++) begin
            @(posedge aclk); #1;
            sco = 1'b0; fso = 1'b0; sdo = w[31-i];
            if (hook == 3 && i == 10) aresetn = 1'b1;
            repeat (HALF) @(posedge aclk);
            #1 sco = 1'b1;
            if (i == 31) last_rise = cyc;
            if (i == 31 && (hook == 1 || hook == 2)) begin
                repeat (3) @(posedge aclk);
                #1 if (hook == 1) m_axis.tready = 1'b1; else clr = 1'b1;
                @(posedge aclk);
                #1 m_axis.tready = 1'b0; clr = 1'b0;
            end else begin
                repeat (HALF-1) @(posedge aclk);
            end
        end
        @(posedge aclk); #1;
        sco = 1'b0; fso = 1'b1;
        repeat (HALF) @(posedge aclk);
        #1 sco = 1'b1;
        repeat (HALF) @(posedge aclk);
        #1 sco = 1'b0;
        repeat (HALF) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_ready();
        @(posedge aclk); #1 m_axis.tready = 1'b1;
        @(posedge aclk); #1 m_axis.tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        n_chk++; if (m_axis.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis.tvalid); else n_pass++;
        n_chk++; if (m_axis.tdata !== 32'h0) $display("FAIL reset_tdata: got %h want 0", m_axis.tdata); else n_pass++;
        n_chk++; if (m_axis.tuser !== 8'h0) $display("FAIL reset_tuser: got %h want 0", m_axis.tuser); else n_pass++;
        n_chk++; if (ovf !== 16'h0) $display("FAIL reset_ovf: got %h want 0", ovf); else n_pass++;
        n_chk++; if (ferr !== 8'h0) $display("FAIL reset_ferr: got %h want 0", ferr); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_frame(32'hDEADBEEF, 32, 3);
        n_chk++; if (m_axis.tvalid !== 1'b0) $display("FAIL midframe_tvalid: got %b want 0", m_axis.tvalid); else n_pass++;
        n_chk++; if (ferr !== exp_ferr) $display("FAIL midframe_ferr: got %h want %h", ferr, exp_ferr); else n_pass++;
        send_frame(32'hABCDEF5A, 32, 0);
        model_full = 1; model_held = beat_of(32'hABCDEF5A);
        n_chk++; if (m_axis.tvalid !== 1'b1) $display("FAIL first_tvalid: got %b want 1", m_axis.tvalid); else n_pass++;
        n_chk++; if (m_axis.tdata !== 32'hFFABCDEF) $display("FAIL first_tdata: got %h want FFABCDEF", m_axis.tdata); else n_pass++;
        n_chk++; if (m_axis.tuser !== 8'h5A) $display("FAIL first_tuser: got %h want 5A", m_axis.tuser); else n_pass++;
        n_chk++; if (z_axis.tdata !== 32'h00ABCDEF) $display("FAIL zext_tdata: got %h want 00ABCDEF", z_axis.tdata); else n_pass++;
    endtask

    task automatic test_sign_latency();
        logic [39:0] b;
        pulse_ready();
        b = (got.size() > 0) ? got.pop_front() : 40'hx;
        n_chk++; if (b !== model_held) $display("FAIL drain_beat: got %h want %h", b, model_held); else n_pass++;
        n_chk++; if (m_axis.tvalid !== 1'b0) $display("FAIL drain_tvalid: got %b want 0", m_axis.tvalid); else n_pass++;
        v_rise_cyc = -1;
        send_frame(32'h12345600, 32, 0);
        model_held = beat_of(32'h12345600);
        n_chk++; if (m_axis.tdata !== 32'h00123456) $display("FAIL pos_tdata: got %h want 00123456", m_axis.tdata); else n_pass++;
        n_chk++; if (m_axis.tuser !== 8'h00) $display("FAIL pos_tuser: got %h want 00", m_axis.tuser); else n_pass++;
        n_chk++; if (v_rise_cyc - last_rise !== SYNC + 2) $display("FAIL latency: got %0d want %0d", v_rise_cyc - last_rise, SYNC + 2); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [39:0] b;
        logic [31:0] f[3];
        pulse_ready();
        void'(got.pop_front());
        model_full = 0;
        for (int k = 0; k < 3; k++) f[k] = $urandom;
        for (int k = 0; k < 3; k++) begin
            send_frame(f[k], 32, 0);
            if (model_full) exp_ovf++; else begin model_full = 1; model_held = beat_of(f[k]); end
            n_chk++; if ({m_axis.tdata, m_axis.tuser} !== model_held) $display("FAIL stall_hold%0d: got %h want %h", k, {m_axis.tdata, m_axis.tuser}, model_held); else n_pass++;
        end
        n_chk++; if (ovf !== 16'd2) $display("FAIL stall_ovf: got %0d want 2", ovf); else n_pass++;
        pulse_ready();
        b = (got.size() == 1) ? got.pop_front() : 40'hx;
        model_full = 0;
        n_chk++; if (b !== model_held) $display("FAIL stall_release_beat: got %h want %h", b, model_held); else n_pass++;
        n_chk++; if (m_axis.tvalid !== 1'b0) $display("FAIL stall_release_tvalid: got %b want 0", m_axis.tvalid); else n_pass++;
    endtask

    task automatic test_frame_error();
        logic [31:0] w;
        send_frame($urandom, 20, 0);
        exp_ferr++;
        n_chk++; if (ferr !== exp_ferr) $display("FAIL ferr_count: got %0d want %0d", ferr, exp_ferr); else n_pass++;
        n_chk++; if (m_axis.tvalid !== 1'b0 || got.size() != 0) $display("FAIL ferr_nobeat: got tvalid %b beats %0d want 0 0", m_axis.tvalid, got.size()); else n_pass++;
        w = $urandom;
        send_frame(w, 32, 0);
        model_full = 1; model_held = beat_of(w);
        n_chk++; if ({m_axis.tdata, m_axis.tuser} !== model_held) $display("FAIL ferr_next: got %h want %h", {m_axis.tdata, m_axis.tuser}, model_held); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [39:0] b;
        logic [31:0] w;
        w = $urandom;
        send_frame(w, 32, 1);
        b = (got.size() == 1) ? got.pop_front() : 40'hx;
        n_chk++; if (b !== model_held) $display("FAIL b2b_old_beat: got %h want %h", b, model_held); else n_pass++;
        model_held = beat_of(w);
        n_chk++; if (m_axis.tvalid !== 1'b1) $display("FAIL b2b_tvalid: got %b want 1", m_axis.tvalid); else n_pass++;
        n_chk++; if ({m_axis.tdata, m_axis.tuser} !== model_held) $display("FAIL b2b_new: got %h want %h", {m_axis.tdata, m_axis.tuser}, model_held); else n_pass++;
        n_chk++; if (ovf !== exp_ovf) $display("FAIL b2b_ovf: got %0d want %0d", ovf, exp_ovf); else n_pass++;
    endtask

    task automatic test_random();
        logic [39:0] b;
        logic [31:0] w;
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1 && model_full) begin
                pulse_ready();
                b = (got.size() > 0) ? got.pop_front() : 40'hx;
                model_full = 0;
                n_chk++; if (b !== model_held) $display("FAIL rnd_beat%0d: got %h want %h", k, b, model_held); else n_pass++;
            end
            w = $urandom;
            send_frame(w, 32, 0);
            if (model_full) exp_ovf++; else begin model_full = 1; model_held = beat_of(w); end
            n_chk++; if ({m_axis.tdata, m_axis.tuser} !== model_held || ovf !== exp_ovf)
                $display("FAIL rnd_frame%0d: got %h/%0d want %h/%0d", k, {m_axis.tdata, m_axis.tuser}, ovf, model_held, exp_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        @(negedge aclk);
        force dut.overflow_cnt = 16'hFFFE;
        #1 release dut.overflow_cnt;
        exp_ovf = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            send_frame($urandom, 32, 0);
            if (exp_ovf != 16'hFFFF) exp_ovf++;
            n_chk++; if (ovf !== exp_ovf) $display("FAIL sat_ovf%0d: got %h want %h", k, ovf, exp_ovf); else n_pass++;
        end
    endtask

    task automatic test_clear();
        @(posedge aclk); #1 clr = 1'b1;
        @(posedge aclk); #1 clr = 1'b0;
        n_chk++; if (ovf !== 16'h0 || ferr !== 8'h0) $display("FAIL clear: got %h/%h want 0/0", ovf, ferr); else n_pass++;
        send_frame($urandom, 32, 2);
        n_chk++; if (ovf !== 16'h0 || ferr !== 8'h0) $display("FAIL clear_vs_inc: got %h/%h want 0/0", ovf, ferr); else n_pass++;
        n_chk++; if ({m_axis.tdata, m_axis.tuser} !== model_held) $display("FAIL clear_hold: got %h want %h", {m_axis.tdata, m_axis.tuser}, model_held); else n_pass++;
    endtask

    initial begin
        m_axis.tready = 1'b0;
        test_reset();
        test_reset_midframe();
        test_sign_latency();
        test_backpressure();
        test_frame_error();
        test_back_to_back();
        test_random();
        test_saturation();
        test_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule : tb_axis_ad7763_rx
`default_nettype wire
